// File: rtl/memory_stage.sv
// memory_stage: MIPS MEM stage with an internal byte-addressed data memory and MEM_WAIT wait states.
// Optional macro MS_MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of force-aligning them.
module memory_stage #(
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned OPCODE_WIDTH = 6,
    parameter int unsigned DEPTH_WORDS  = 256,
    parameter int unsigned MEM_WAIT     = 2
) (
    input  logic                    ms_i_clk,
    input  logic                    ms_i_rst_n,
    input  logic                    ms_i_ce,
    input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
    input  logic [DWIDTH-1:0]       ms_i_alu_value,
    input  logic [DWIDTH-1:0]       ms_i_data_rt,
    input  logic [4:0]              ms_i_rd_addr,
    output logic                    ms_o_stall,
    output logic                    ms_o_ce,
    output logic [DWIDTH-1:0]       ms_o_wb_data,
    output logic [4:0]              ms_o_rd_addr,
    output logic [OPCODE_WIDTH-1:0] ms_o_opcode,
    output logic                    ms_o_misaligned
);
    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam int unsigned CW      = 4;
    localparam bit          NO_WAIT = (MEM_WAIT == 0);

    localparam logic [OPCODE_WIDTH-1:0] OP_LB  = OPCODE_WIDTH'(8'h20);
    localparam logic [OPCODE_WIDTH-1:0] OP_LH  = OPCODE_WIDTH'(8'h21);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW  = OPCODE_WIDTH'(8'h23);
    localparam logic [OPCODE_WIDTH-1:0] OP_LBU = OPCODE_WIDTH'(8'h24);
    localparam logic [OPCODE_WIDTH-1:0] OP_LHU = OPCODE_WIDTH'(8'h25);
    localparam logic [OPCODE_WIDTH-1:0] OP_SB  = OPCODE_WIDTH'(8'h28);
    localparam logic [OPCODE_WIDTH-1:0] OP_SH  = OPCODE_WIDTH'(8'h29);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW  = OPCODE_WIDTH'(8'h2B);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [OPCODE_WIDTH-1:0] lat_op_q, lat_op_d;
    logic [DWIDTH-1:0]       lat_addr_q, lat_addr_d;
    logic [DWIDTH-1:0]       lat_data_q, lat_data_d;
    logic [4:0]              lat_rd_q, lat_rd_d;
    logic                    ce_q, ce_d;
    logic [DWIDTH-1:0]       wb_q, wb_d;
    logic [4:0]              rd_q, rd_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic                    mis_q, mis_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic                    in_is_mem, start_busy;
    logic                    acc_fire, acc_ld, acc_st;
    logic [OPCODE_WIDTH-1:0] acc_op;
    logic [DWIDTH-1:0]       acc_addr, acc_data;
    logic [4:0]              acc_rd;
    logic                    sz_half, sz_word, ld_signed, trap;
    logic [1:0]              lane_raw, lane;
    logic [AW-1:0]           word_idx;
    logic [31:0]             rd_word, wdata;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;
    logic [3:0]              be;
    logic                    mem_we;
    logic [DWIDTH-1:0]       load_v;

    function automatic logic is_load(input logic [OPCODE_WIDTH-1:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [OPCODE_WIDTH-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // In BUSY the latched bundle drives the access; in IDLE the live inputs do.
    always_comb begin
        in_is_mem  = is_load(ms_i_opcode) || is_store(ms_i_opcode);
        start_busy = (state_q == S_IDLE) && ms_i_ce && in_is_mem && !NO_WAIT;
        acc_op     = (state_q == S_BUSY) ? lat_op_q   : ms_i_opcode;
        acc_addr   = (state_q == S_BUSY) ? lat_addr_q : ms_i_alu_value;
        acc_data   = (state_q == S_BUSY) ? lat_data_q : ms_i_data_rt;
        acc_rd     = (state_q == S_BUSY) ? lat_rd_q   : ms_i_rd_addr;
        acc_fire   = (state_q == S_BUSY) ? (cnt_q == CW'(1))
                                         : (ms_i_ce && (!in_is_mem || NO_WAIT));
    end

    always_comb begin
        acc_ld    = is_load(acc_op);
        acc_st    = is_store(acc_op);
        sz_half   = acc_op inside {OP_LH, OP_LHU, OP_SH};
        sz_word   = acc_op inside {OP_LW, OP_SW};
        ld_signed = acc_op inside {OP_LB, OP_LH};
        lane_raw  = acc_addr[1:0];
`ifdef MS_MISALIGN_TRAP_EN
        lane = lane_raw;
        trap = (acc_ld || acc_st) &&
               ((sz_half && lane_raw[0]) || (sz_word && (lane_raw != 2'b00)));
`else
        lane = sz_word ? 2'b00 : (sz_half ? {lane_raw[1], 1'b0} : lane_raw);
        trap = 1'b0;
`endif
    end

    // Little-endian lane extraction, byte enables and replicated store data.
    always_comb begin
        word_idx = acc_addr[AW+1:2];
        rd_word  = mem[word_idx];
        byte_v   = rd_word[{lane, 3'b000} +: 8];
        half_v   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        if (sz_word) begin
            load_v = DWIDTH'(rd_word);
            be     = 4'b1111;
            wdata  = acc_data[31:0];
        end else if (sz_half) begin
            load_v = {{(DWIDTH-16){ld_signed & half_v[15]}}, half_v};
            be     = lane[1] ? 4'b1100 : 4'b0011;
            wdata  = {2{acc_data[15:0]}};
        end else begin
            load_v = {{(DWIDTH-8){ld_signed & byte_v[7]}}, byte_v};
            be     = 4'b0001 << lane;
            wdata  = {4{acc_data[7:0]}};
        end
        mem_we = ms_i_rst_n && acc_fire && acc_st && !trap;
    end

    always_ff @(posedge ms_i_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge ms_i_clk) begin
        if (!ms_i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_busy) begin
                    state_d = S_BUSY;
                    cnt_d   = CW'(MEM_WAIT);
                end
            end
            S_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lat_op_d   = lat_op_q;
        lat_addr_d = lat_addr_q;
        lat_data_d = lat_data_q;
        lat_rd_d   = lat_rd_q;
        ce_d       = 1'b0;
        wb_d       = wb_q;
        rd_d       = rd_q;
        op_d       = op_q;
        mis_d      = mis_q;
        if (start_busy) begin
            lat_op_d   = ms_i_opcode;
            lat_addr_d = ms_i_alu_value;
            lat_data_d = ms_i_data_rt;
            lat_rd_d   = ms_i_rd_addr;
        end
        if (acc_fire) begin
            ce_d  = 1'b1;
            op_d  = acc_op;
            rd_d  = acc_rd;
            mis_d = trap;
            if (acc_ld)      wb_d = trap ? '0 : load_v;
            else if (acc_st) wb_d = '0;
            else             wb_d = acc_addr;
        end
    end

    always_ff @(posedge ms_i_clk) begin
        if (!ms_i_rst_n) begin
            lat_op_q   <= '0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            lat_rd_q   <= '0;
            ce_q       <= 1'b0;
            wb_q       <= '0;
            rd_q       <= '0;
            op_q       <= '0;
            mis_q      <= 1'b0;
        end else begin
            lat_op_q   <= lat_op_d;
            lat_addr_q <= lat_addr_d;
            lat_data_q <= lat_data_d;
            lat_rd_q   <= lat_rd_d;
            ce_q       <= ce_d;
            wb_q       <= wb_d;
            rd_q       <= rd_d;
            op_q       <= op_d;
            mis_q      <= mis_d;
        end
    end

    assign ms_o_stall      = (state_q == S_BUSY);
    assign ms_o_ce         = ce_q;
    assign ms_o_wb_data    = wb_q;
    assign ms_o_rd_addr    = rd_q;
    assign ms_o_opcode     = op_q;
    assign ms_o_misaligned = mis_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed scoreboard bench for memory_stage with MEM_WAIT=2.
// Misalignment expectations follow MS_MISALIGN_TRAP_EN when it is defined.
module tb_memory_stage;
    localparam int unsigned WAIT = 2;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [5:0]  op;
        logic        mis;
        int          lat;
        time         acc_t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_ce = 1'b0;
    logic [5:0]  i_op = '0;
    logic [31:0] i_alu = '0;
    logic [31:0] i_rt = '0;
    logic [4:0]  i_rd = '0;
    logic        o_stall, o_ce, o_mis;
    logic [31:0] o_wb;
    logic [4:0]  o_rd;
    logic [5:0]  o_op;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  mb [1024];
    int          checks = 0;
    int          errors = 0;
    int          stall_run = 0;

    memory_stage #(
        .DWIDTH(32), .OPCODE_WIDTH(6), .DEPTH_WORDS(256), .MEM_WAIT(WAIT)
    ) dut (
        .ms_i_clk(clk), .ms_i_rst_n(rst_n), .ms_i_ce(i_ce), .ms_i_opcode(i_op),
        .ms_i_alu_value(i_alu), .ms_i_data_rt(i_rt), .ms_i_rd_addr(i_rd),
        .ms_o_stall(o_stall), .ms_o_ce(o_ce), .ms_o_wb_data(o_wb),
        .ms_o_rd_addr(o_rd), .ms_o_opcode(o_op), .ms_o_misaligned(o_mis)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-level reference memory; returns the writeback the DUT should produce.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [4:0] rd);
        exp_t        e;
        int          sz;
        bit          ld, st, sgn, trap;
        logic [9:0]  a;
        logic [31:0] v;
        ld   = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        st   = op inside {6'h28, 6'h29, 6'h2B};
        sz   = (op inside {6'h20, 6'h24, 6'h28}) ? 1 :
               (op inside {6'h21, 6'h25, 6'h29}) ? 2 : 4;
        sgn  = op inside {6'h20, 6'h21};
        a    = addr[9:0];
        trap = 1'b0;
        if ((ld || st) && (sz > 1) && ((a % sz) != 0)) begin
`ifdef MS_MISALIGN_TRAP_EN
            trap = 1'b1;
`else
            a = a - 10'(a % sz);
`endif
        end
        v = '0;
        if (st && !trap) for (int i = 0; i < sz; i++) mb[a + 10'(i)] = data[8*i +: 8];
        if (ld && !trap) begin
            for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[a + 10'(i)];
            if (sgn && v[8*sz-1]) for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
        end
        e.data  = (ld || st) ? v : addr;
        e.rd    = rd;
        e.op    = op;
        e.mis   = trap;
        e.lat   = (ld || st) ? int'(WAIT) + 1 : 1;
        e.acc_t = 0;
        return e;
    endfunction

    // Present a bundle and hold it until the DUT consumes it; returns at a negedge.
    task automatic send(input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd);
        exp_t e;
        bit   taken;
        i_ce  = 1'b1;
        i_op  = op;
        i_alu = addr;
        i_rt  = data;
        i_rd  = rd;
        taken = 1'b0;
        for (int n = 0; n < 40 && !taken; n++) begin
            taken = (o_stall === 1'b0);
            @(posedge clk);
            if (taken) begin
                e       = model(op, addr, data, rd);
                e.acc_t = $time;
                exp_q.push_back(e);
            end
            @(negedge clk);
        end
        chk("accepted", 32'(taken), 32'd1);
    endtask

    task automatic idle(input int n);
        i_ce = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ce", 32'(o_ce), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_wb_data", o_wb, 32'd0);
        chk("rst_rd", 32'(o_rd), 32'd0);
        chk("rst_opcode", 32'(o_op), 32'd0);
        chk("rst_misaligned", 32'(o_mis), 32'd0);
    endtask

    // Scoreboard: every writeback pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (o_ce === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_spurious_ce: observed ce=1 with %0d pending, expected none", exp_q.size());
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wb_data", o_wb, mon_e.data);
                chk("rd_addr", 32'(o_rd), 32'(mon_e.rd));
                chk("opcode", 32'(o_op), 32'(mon_e.op));
                chk("misaligned", 32'(o_mis), 32'(mon_e.mis));
                chk("stall_at_ce", 32'(o_stall), 32'd0);
                chk("latency_edges", 32'(($time - mon_e.acc_t + 5) / 10), 32'(mon_e.lat));
                chk("stall_cycles", 32'(stall_run), 32'(mon_e.lat - 1));
            end
            stall_run = 0;
        end else if (o_stall === 1'b1) begin
            stall_run++;
        end else begin
            stall_run = 0;
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        idle(1);

        send(6'h00, 32'h0000_1234, 32'h0, 5'd5);
        idle(2);
        send(6'h22, 32'hABCD_0000, 32'h55, 5'd31);
        idle(1);

        send(6'h2B, 32'h10, 32'hDEAD_BEEF, 5'd0);
        send(6'h23, 32'h10, 32'h0, 5'd8);
        idle(4);

        send(6'h28, 32'h11, 32'h0000_0080, 5'd0);
        send(6'h20, 32'h11, 32'h0, 5'd9);
        send(6'h24, 32'h11, 32'h0, 5'd10);
        send(6'h23, 32'h10, 32'h0, 5'd11);
        idle(4);

        send(6'h29, 32'h12, 32'h0000_8001, 5'd0);
        send(6'h21, 32'h12, 32'h0, 5'd12);
        send(6'h25, 32'h12, 32'h0, 5'd13);
        idle(4);

        send(6'h23, 32'h13, 32'h0, 5'd14);
        idle(4);

        // Reset during BUSY must abandon the pending store.
        send(6'h2B, 32'h20, 32'h1111_1111, 5'd0);
        idle(4);
        i_ce = 1'b1; i_op = 6'h2B; i_alu = 32'h20; i_rt = 32'h2222_2222; i_rd = 5'd0;
        @(posedge clk);
        @(negedge clk);
        i_ce = 1'b0;
        chk("stall_busy", 32'(o_stall), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        idle(1);
        send(6'h23, 32'h20, 32'h0, 5'd15);
        idle(4);

        // Wrapped store, ALU op held during stall, then dependent load.
        send(6'h2B, 32'h0000_1410, 32'hCAFE_F00D, 5'd0);
        send(6'h00, 32'h0000_0777, 32'h0, 5'd3);
        send(6'h23, 32'h10, 32'h0, 5'd16);
        idle(6);

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. It consumes the execute-stage result bundle: ALU value, valid/ce, opcode, store data and destination register.
- Performs loads and stores against an internal byte-addressed data memory with a configurable wait-state count.
- Returns stall to upstream while busy, and presents a registered writeback bundle to the WB stage.

Parameters:
- DWIDTH, 32, data/address width.
- OPCODE_WIDTH, 6, opcode width.
- DEPTH_WORDS, 256, data memory size in 32-bit words; power of 2.
- MEM_WAIT, 2, extra cycles per load/store (0..15); non-memory ops are never delayed.

Ports:
- ms_i_clk  in  1  clock, rising edge.
- ms_i_rst_n  in  1  synchronous active-low reset.
- ms_i_ce  in  1  execute result valid.
- ms_i_opcode  in  OPCODE_WIDTH  opcode from execute.
- ms_i_alu_value  in  DWIDTH  ALU result; this is the memory byte address for loads/stores.
- ms_i_data_rt  in  DWIDTH  store data.
- ms_i_rd_addr  in  5  writeback register index.
- ms_o_stall  out  1  upstream must hold its bundle.
- ms_o_ce  out  1  writeback bundle valid, one-cycle pulse per instruction.
- ms_o_wb_data  out  DWIDTH  load data or passed-through ALU value.
- ms_o_rd_addr  out  5  writeback register index.
- ms_o_opcode  out  OPCODE_WIDTH  opcode passed through.
- ms_o_misaligned  out  1  misaligned access flag, valid with ms_o_ce.

Behaviour:
- Reset (ms_i_rst_n=0 at clock edge):
  - All outputs go to 0; FSM goes to IDLE; wait counter goes to 0.
  - Memory contents are not cleared.
  - Reset mid-BUSY abandons the access; a pending store is not performed.
- Opcode decode:
  - Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - Stores: SB 0x28, SH 0x29, SW 0x2B.
  - All others are non-memory.
- Addressing:
  - word index = alu_value[log2(DEPTH_WORDS)+1:2], wrapping modulo depth.
  - Byte lane = alu_value[1:0]; little-endian (lane 0 = bits 7:0).
- FSM states: IDLE, BUSY.
- IDLE, ms_i_ce=0: ms_o_ce=0 next cycle; other outputs hold.
- IDLE, ms_i_ce=1, non-memory op, next edge:
  - ms_o_ce=1, ms_o_wb_data=alu_value; rd/opcode registered.
  - Latency 1; ms_o_stall stays 0.
- IDLE, ms_i_ce=1, memory op, MEM_WAIT=0: same as non-memory (latency 1, no stall); the access executes at that edge.
- IDLE, ms_i_ce=1, memory op, MEM_WAIT>0:
  - Latch opcode/address/data/rd.
  - Go to BUSY with counter=MEM_WAIT; ms_o_stall=1 combinationally from that edge on.
- BUSY:
  - Counter decrements each cycle; inputs are ignored; ms_o_ce=0.
  - When counter reaches 1, the next edge performs the access, pulses ms_o_ce=1 and returns to IDLE.
  - ms_o_stall drops in the cycle ms_o_ce is high.
  - Total latency is MEM_WAIT+1 edges.
- Store:
  - SB writes only the addressed byte lane.
  - SH writes lanes {1:0} or {3:2}.
  - SW writes all four lanes.
  - Store data comes from the low bits of data_rt.
  - ms_o_wb_data=0 for stores; ms_o_ce still pulses so WB sees the slot.
- Load: reads the word at the access edge.
  - LB/LH sign-extend the selected lane(s).
  - LBU/LHU zero-extend.
  - LW returns the full word.
- Store then load to the same address in consecutive instructions: the load returns the new data, because the write commits before the load's access edge.
- Simultaneous ms_i_ce with ms_o_stall=1: the upstream holds its bundle, so the input is not consumed; it is re-sampled on the first IDLE cycle.

Optional Feature:
- Macro: MS_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, sets ms_o_misaligned=1 with ms_o_ce.
  - The store is suppressed; the load returns 0.
- Not defined:
  - ms_o_misaligned is tied to 0.
  - Addresses are force-aligned: low bit cleared for halfwords, low two bits cleared for words.
  - The access proceeds.

Test Plan:
- Reset low for 2 cycles mid-BUSY (MEM_WAIT=2) -> all outputs 0, FSM IDLE, and no memory write at the target address (a later LW reads the old value).
- ADD-type op 0x00, alu_value=0x1234, rd=5 -> next cycle ms_o_ce=1, wb_data=0x1234, rd=5, stall never asserted.
- SW 0xDEADBEEF to 0x10, then LW 0x10 (MEM_WAIT=2) -> stall high 2 cycles per access; ms_o_ce 3 edges after each acceptance; load returns 0xDEADBEEF.
- SB 0x80 to 0x11, then LB 0x11 -> wb_data=0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
- SH 0x8001 to 0x12, then LH 0x12 -> 0xFFFF8001; LHU -> 0x00008001.
- LW at 0x13:
  - with MS_MISALIGN_TRAP_EN -> misaligned=1, wb_data=0.
  - without the macro -> misaligned=0, reads word 0x10.
